// File: rtl/channel_scheduler.sv
// channel_scheduler: byte-serial frame loader with double buffering, feeding one shared
// spike detector channel by channel and publishing the per-channel results atomically.
module channel_scheduler #(
   parameter int unsigned NUM_CHANNELS = 4,
   parameter int unsigned DATA_WIDTH   = 16,
   localparam int unsigned FRAME_W     = NUM_CHANNELS * DATA_WIDTH,
   localparam int unsigned BYTES       = FRAME_W / 8,
   localparam int unsigned CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [7:0]              wr_data,
   input  logic                    start,
   input  logic [CH_W-1:0]         ch_sel,
   output logic                    det_valid,
   output logic [CH_W-1:0]         det_ch,
   output logic [DATA_WIDTH-1:0]   det_sample,
   input  logic                    det_ready,
   input  logic                    res_valid,
   input  logic                    res_event,
   output logic [NUM_CHANNELS-1:0] event_flags,
   output logic                    sel_event,
   output logic                    busy,
   output logic                    done,
   output logic                    frame_full,
   output logic                    overrun
);

   localparam int unsigned WP_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [WP_W-1:0] WP_TOP  = WP_W'(BYTES - 1);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   state_e                  state_q;
   logic [CH_W-1:0]         idx_q;
   logic [FRAME_W-1:0]      load_q;
   logic [FRAME_W-1:0]      work_q;
   logic [NUM_CHANNELS-1:0] acc_q;
   logic [WP_W-1:0]         wp_q;

   logic                    start_ok;
   logic [WP_W-1:0]         wp_eff;
   logic                    full_eff;

   assign start_ok = start && (state_q == StIdle) && frame_full;

   // An accepted start frees the load buffer this cycle, so a same-cycle write opens the next frame
   always_comb begin
      wp_eff   = wp_q;
      full_eff = frame_full;
      if (start_ok) begin
         wp_eff   = WP_TOP;
         full_eff = 1'b0;
      end
   end

   // Load buffer: MSB-first byte assembly, full flag and sticky protocol-violation flag
   always_ff @(posedge clk) begin
      if (rst) begin
         load_q     <= '0;
         wp_q       <= WP_TOP;
         frame_full <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         wp_q       <= wp_eff;
         frame_full <= full_eff;
         if (wr_en && !full_eff) begin
            load_q[{wp_eff, 3'b000} +: 8] <= wr_data;
            if (wp_eff == '0) begin
               frame_full <= 1'b1;
               wp_q       <= WP_TOP;
            end else begin
               wp_q <= wp_eff - 1'b1;
            end
         end
         if ((wr_en && full_eff) || (start && !start_ok)) begin
            overrun <= 1'b1;
         end
      end
   end

   // Sequencer: snapshot frame, issue channels in order, collect results, publish on completion
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         work_q      <= '0;
         acc_q       <= '0;
         event_flags <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_ok) begin
                  work_q  <= load_q;
                  idx_q   <= '0;
                  state_q <= StIssue;
               end
            end
            StIssue: begin
               if (det_ready) begin
                  state_q <= StWait;
               end
            end
            StWait: begin
               if (res_valid) begin
                  acc_q[idx_q] <= res_event;
                  if (idx_q == LAST_CH) begin
                     state_q <= StDone;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                     state_q <= StIssue;
                  end
               end
            end
            StDone: begin
               event_flags <= acc_q;
               state_q     <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Registered per-channel event view; out-of-range selections read as no event
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_event <= 1'b0;
      end else begin
         sel_event <= (32'(ch_sel) < NUM_CHANNELS) ? event_flags[ch_sel] : 1'b0;
      end
   end

   assign det_valid  = (state_q == StIssue);
   assign det_ch     = idx_q;
   assign det_sample = work_q[idx_q * DATA_WIDTH +: DATA_WIDTH];
   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StDone);

endmodule
